// File: rtl/game_pkg.sv
// game_pkg: shared encodings and default timing/bonus constants for game_ctrl
package game_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READY    = 3'd1,
    PLAY     = 3'd2,
    DEATH    = 3'd3,
    WIN      = 3'd4,
    GAMEOVER = 3'd5
  } game_state_e;
  typedef enum logic [2:0] {
    M_INITIAL  = 3'd0,
    M_STANDING = 3'd1,
    M_WALKING  = 3'd2,
    M_JUMPING  = 3'd3,
    M_FALLING  = 3'd4,
    M_DYING    = 3'd5,
    M_CLAMPING = 3'd6
  } mario_state_e;
  localparam int K_UP    = 0;
  localparam int K_LEFT  = 1;
  localparam int K_RIGHT = 2;
  localparam int K_DOWN  = 3;
  localparam int K_JUMP  = 4;
  localparam int DEF_LIVES_INIT   = 3;
  localparam int DEF_INTRO_FRAMES = 60;
  localparam int DEF_DEATH_FRAMES = 120;
  localparam int DEF_WIN_FRAMES   = 90;
  localparam int DEF_BONUS_INIT   = 5000;
  localparam int DEF_BONUS_DEC    = 100;
  localparam int DEF_BONUS_PERIOD = 120;
  localparam int DEF_WIN_Y        = 50;
  // every frame limit must fit this counter width
  localparam int CNT_W = 8;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: frame counter with synchronous clear and terminal-count detect
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         tick_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o = tick_i && (cnt_q == limit_i - 1'b1);
  always_comb cnt_d = (clr_i || tc_o) ? '0 : tick_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game flow FSM with lives, level, score and bonus bookkeeping
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT   = DEF_LIVES_INIT,
  parameter int INTRO_FRAMES = DEF_INTRO_FRAMES,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int WIN_FRAMES   = DEF_WIN_FRAMES,
  parameter int BONUS_INIT   = DEF_BONUS_INIT,
  parameter int BONUS_DEC    = DEF_BONUS_DEC,
  parameter int BONUS_PERIOD = DEF_BONUS_PERIOD,
  parameter int WIN_Y        = DEF_WIN_Y
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [4:0]  keydown,
  input  logic        hit,
  input  logic [8:0]  mario_y,
  input  logic [2:0]  mario_state,
  output logic        mario_rst,
  output logic        mario_start,
  output logic        mario_over,
  output logic [2:0]  game_state,
  output logic [1:0]  lives,
  output logic [2:0]  level,
  output logic [15:0] score,
  output logic [12:0] bonus
);
  game_state_e state_q, state_d;
  logic jump_q, start, tc, entry, win;
  logic [CNT_W-1:0] limit;
  logic [1:0] lives_q, lives_d;
  logic [2:0] level_q, level_d;
  logic [15:0] score_q, score_d;
  logic [12:0] bonus_q, bonus_d;
  logic [16:0] score_sum;
  logic unused_keys;
  assign unused_keys = ^keydown[3:0];
  assign start = keydown[K_JUMP] && !jump_q;
  assign win = (mario_y <= 9'(WIN_Y)) && (mario_state != M_DYING);
  assign entry = state_d != state_q;
  assign score_sum = {1'b0, score_q} + 17'(bonus_q);
  // the timer also paces bonus decay in PLAY, wrapping every BONUS_PERIOD ticks
  always_comb
    limit = state_q == READY ? CNT_W'(INTRO_FRAMES) :
            state_q == DEATH ? CNT_W'(DEATH_FRAMES) :
            state_q == WIN   ? CNT_W'(WIN_FRAMES)   : CNT_W'(BONUS_PERIOD);
  frame_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (entry),
    .tick_i (frame_tick),
    .limit_i(limit),
    .tc_o   (tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start ? READY : IDLE;
      READY:    state_d = tc ? PLAY : READY;
      PLAY:     state_d = (hit || bonus_q == '0) ? DEATH : win ? WIN : PLAY;
      DEATH:    state_d = !tc ? DEATH : (lives_q == 2'd1) ? GAMEOVER : READY;
      WIN:      state_d = tc ? READY : WIN;
      GAMEOVER: state_d = start ? IDLE : GAMEOVER;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    lives_d = lives_q;
    level_d = level_q;
    score_d = score_q;
    bonus_d = bonus_q;
    if (state_q == IDLE && state_d == READY) begin
      lives_d = 2'(LIVES_INIT);
      score_d = '0;
      level_d = 3'd1;
    end
    if (entry && state_d == READY) bonus_d = 13'(BONUS_INIT);
    if (state_q == PLAY && state_d == PLAY && tc)
      bonus_d = (bonus_q > 13'(BONUS_DEC)) ? bonus_q - 13'(BONUS_DEC) : '0;
    if (entry && state_d == WIN) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      level_d = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
    end
    if (entry && state_q == DEATH) lives_d = lives_q - 2'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      jump_q  <= 1'b0;
      lives_q <= '0;
      level_q <= '0;
      score_q <= '0;
      bonus_q <= '0;
    end else begin
      jump_q  <= keydown[K_JUMP];
      lives_q <= lives_d;
      level_q <= level_d;
      score_q <= score_d;
      bonus_q <= bonus_d;
    end
  always_comb begin
    game_state  = state_q;
    mario_rst   = state_q inside {IDLE, READY};
    mario_over  = state_q inside {DEATH, GAMEOVER};
    mario_start = (state_q == READY) && (state_d == PLAY);
  end
  assign lives = lives_q;
  assign level = level_q;
  assign score = score_q;
  assign bonus = bonus_q;
endmodule
